miner_work_ctrl: RTL and testbench

Work scheduler and result collector for one `miner66` hashing core. It accepts jobs (midstate plus 96-bit tail data) from the host-side interface over a valid/ready handshake, and holds the active job stable on the core inputs. It sequences the core's reset so every new job starts from a clean pipeline and nonce origin. It then watches the core's `golden_nonce` output and queues each new hit, tagged with its job ID, into a small FIFO for host readout.

---
 rtl/miner_ctrl_pkg.sv | 22 ++
 rtl/hit_fifo.sv | 52 +++++
 rtl/miner_work_ctrl.sv | 168 ++++++++++++++++
 tb/tb_miner_work_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_ctrl_pkg.sv
// Shared types and constants for the miner66 work controller.
// Holds the controller state encoding and the hit-record layout width.
package miner_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_EXH  = 2'd3
  } ctrl_state_t;

  localparam int NONCE_W              = 32;
  localparam int DEFAULT_ID_W         = 8;
  localparam int DEFAULT_RESET_CYCLES = 264;
  localparam int HIT_REC_W            = NONCE_W + DEFAULT_ID_W;

  // A hit record is {golden nonce, job tag}.
  function automatic int hit_rec_w(input int id_w);
    return NONCE_W + id_w;
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// Small registered FIFO holding tagged golden-nonce hits for host readout.
// No fall-through: a pushed entry becomes visible the cycle after the push.
module hit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/miner_work_ctrl.sv
// Work scheduler for one miner66 core: holds the active job, sequences the
// core reset per job, and queues each new golden nonce tagged with its job ID.
module miner_work_ctrl
  import miner_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int FIFO_DEPTH   = 4,
  parameter int ID_W         = DEFAULT_ID_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            work_valid,
  output logic            work_ready,
  input  logic [255:0]    work_midstate,
  input  logic [95:0]     work_data,
  input  logic [ID_W-1:0] work_id,
  output logic [255:0]    miner_midstate,
  output logic [95:0]     miner_data,
  output logic            miner_reset,
  input  logic [31:0]     miner_golden,
  input  logic [31:0]     miner_nonce2,
  output logic            hit_valid,
  input  logic            hit_ready,
  output logic [31:0]     hit_nonce,
  output logic [ID_W-1:0] hit_id,
  output logic            hit_overflow,
  output logic            busy,
  output logic            exhausted,
  output logic [31:0]     nonce_cur
);
  localparam int REC_W = hit_rec_w(ID_W);
  localparam int CNT_W = $clog2(RESET_CYCLES + 1);

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic [1:0]       rst_sync;
  logic             rst_n_int;
  logic [CNT_W-1:0] load_cnt;
  logic [ID_W-1:0]  active_id;
  logic [31:0]      last_golden;
  logic [31:0]      prev_nonce;
  logic             pend_valid;
  logic [REC_W-1:0] pend_rec;
  logic             accept;
  logic             hashing;
  logic             golden_changed;
  logic             detect;
  logic             wrap;
  logic             load_done;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow_evt;
  logic [REC_W-1:0] fifo_head;

  // Assertion is immediate; release is delayed two clocks to avoid metastability.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign work_ready     = (state != ST_LOAD);
  assign accept         = work_valid && work_ready;
  assign hashing        = ((state == ST_RUN) || (state == ST_EXH)) && !accept;
  assign golden_changed = hashing && (miner_golden != last_golden);
  assign detect         = golden_changed && (miner_golden != '0);
  assign wrap           = (state == ST_RUN) && !accept && (miner_nonce2 < prev_nonce);
  assign load_done      = (state == ST_LOAD) && (load_cnt == '0);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    miner_reset = 1'b1;
    busy        = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_LOAD;
      ST_LOAD: begin
        busy = 1'b1;
        if (load_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        miner_reset = 1'b0;
        busy        = 1'b1;
        if (accept)    state_nxt = ST_LOAD;
        else if (wrap) state_nxt = ST_EXH;
      end
      ST_EXH: begin
        miner_reset = 1'b0;
        if (accept) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Hits are staged one cycle before the FIFO; a new job discards the staged hit.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      miner_midstate <= '0;
      miner_data     <= '0;
      active_id      <= '0;
      load_cnt       <= '0;
      last_golden    <= '0;
      prev_nonce     <= '0;
      nonce_cur      <= '0;
      pend_valid     <= 1'b0;
      pend_rec       <= '0;
    end else begin
      nonce_cur  <= miner_nonce2;
      pend_valid <= detect;
      pend_rec   <= {miner_golden, active_id};
      if (accept) begin
        miner_midstate <= work_midstate;
        miner_data     <= work_data;
        active_id      <= work_id;
        load_cnt       <= CNT_W'(RESET_CYCLES - 1);
      end else if ((state == ST_LOAD) && !load_done) begin
        load_cnt <= load_cnt - CNT_W'(1);
      end
      if (load_done) begin
        last_golden <= '0;
        prev_nonce  <= miner_nonce2;
      end else begin
        if (golden_changed)                 last_golden <= miner_golden;
        if ((state == ST_RUN) && !accept)   prev_nonce  <= miner_nonce2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      exhausted    <= 1'b0;
      hit_overflow <= 1'b0;
    end else if (accept) begin
      exhausted    <= 1'b0;
      hit_overflow <= 1'b0;
    end else begin
      if (wrap)         exhausted    <= 1'b1;
      if (overflow_evt) hit_overflow <= 1'b1;
    end
  end

  assign fifo_push    = pend_valid && !accept;
  assign overflow_evt = fifo_push && fifo_full && !hit_ready;

  hit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_hit_fifo (
    .clk       (clk),
    .reset_n   (rst_n_int),
    .push      (fifo_push),
    .push_data (pend_rec),
    .pop       (hit_ready),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign hit_valid = !fifo_empty;
  assign hit_nonce = fifo_head[REC_W-1 -: 32];
  assign hit_id    = fifo_head[ID_W-1:0];

endmodule

// File: tb/tb_miner_work_ctrl.sv
// Self-checking bench for miner_work_ctrl: directed vectors for the job/hit
// corner cases plus randomized traffic compared against a behavioural model.
module tb_miner_work_ctrl;
  localparam int RESET_CYCLES = 264;
  localparam int DEPTH        = 4;
  localparam int NVEC         = 17;

  logic         clk;
  logic         reset_n;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] work_midstate;
  logic [95:0]  work_data;
  logic [7:0]   work_id;
  logic [255:0] miner_midstate;
  logic [95:0]  miner_data;
  logic         miner_reset;
  logic [31:0]  miner_golden;
  logic [31:0]  miner_nonce2;
  logic         hit_valid;
  logic         hit_ready;
  logic [31:0]  hit_nonce;
  logic [7:0]   hit_id;
  logic         hit_overflow;
  logic         busy;
  logic         exhausted;
  logic [31:0]  nonce_cur;

  int checks = 0;
  int errors = 0;

  miner_work_ctrl #(
    .RESET_CYCLES (RESET_CYCLES),
    .FIFO_DEPTH   (DEPTH),
    .ID_W         (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .work_valid     (work_valid),
    .work_ready     (work_ready),
    .work_midstate  (work_midstate),
    .work_data      (work_data),
    .work_id        (work_id),
    .miner_midstate (miner_midstate),
    .miner_data     (miner_data),
    .miner_reset    (miner_reset),
    .miner_golden   (miner_golden),
    .miner_nonce2   (miner_nonce2),
    .hit_valid      (hit_valid),
    .hit_ready      (hit_ready),
    .hit_nonce      (hit_nonce),
    .hit_id         (hit_id),
    .hit_overflow   (hit_overflow),
    .busy           (busy),
    .exhausted      (exhausted),
    .nonce_cur      (nonce_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 = no job, 1 = core in reset, 2 = hashing, 3 = wrapped.
  typedef struct packed {
    logic [31:0] nonce;
    logic [7:0]  id;
  } hit_t;

  hit_t         m_q[$];
  int           m_mode;
  int           m_left;
  int           m_sync;
  logic [31:0]  m_last;
  logic [31:0]  m_prev;
  logic [31:0]  m_nonce_cur;
  bit           m_exh;
  bit           m_ovf;
  bit           m_pend;
  hit_t         m_pend_rec;
  logic [7:0]   m_id;
  logic [255:0] m_mid;
  logic [95:0]  m_data;

  task automatic model_reset();
    m_q.delete();
    m_mode = 0; m_left = 0; m_sync = 0;
    m_last = '0; m_prev = '0; m_nonce_cur = '0;
    m_exh = 1'b0; m_ovf = 1'b0; m_pend = 1'b0; m_pend_rec = '0;
    m_id = '0; m_mid = '0; m_data = '0;
  endtask

  task automatic model_step();
    int   old_mode;
    bit   acc;
    bit   hashing;
    bit   new_pend;
    hit_t new_rec;
    old_mode = m_mode;
    acc      = work_valid && (old_mode != 1);
    hashing  = (old_mode >= 2) && !acc;
    new_pend = hashing && (miner_golden != m_last) && (miner_golden != 0);
    new_rec  = '{nonce: miner_golden, id: m_id};
    if (hit_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pend && !acc) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pend_rec);
      else                    m_ovf = 1'b1;
    end
    if (hashing && miner_golden != m_last) m_last = miner_golden;
    if (old_mode == 2 && !acc) begin
      if (miner_nonce2 < m_prev) begin
        m_mode = 3;
        m_exh  = 1'b1;
      end
      m_prev = miner_nonce2;
    end else if (old_mode == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 2;
        m_last = '0;
        m_prev = miner_nonce2;
      end
    end
    if (acc) begin
      m_mode = 1; m_left = RESET_CYCLES;
      m_exh = 1'b0; m_ovf = 1'b0;
      m_id = work_id; m_mid = work_midstate; m_data = work_data;
    end
    m_pend      = new_pend;
    m_pend_rec  = new_rec;
    m_nonce_cur = miner_nonce2;
  endtask

  always @(posedge clk) begin
    if (!reset_n)        model_reset();
    else if (m_sync < 2) m_sync++;
    else                 model_step();
  end

  always @(negedge reset_n) model_reset();

  task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_output();
    check_val("m_miner_reset", miner_reset, (m_mode == 0 || m_mode == 1));
    check_val("m_work_ready",  work_ready,  (m_mode != 1));
    check_val("m_busy",        busy,        (m_mode == 1 || m_mode == 2));
    check_val("m_exhausted",   exhausted,   m_exh);
    check_val("m_overflow",    hit_overflow, m_ovf);
    check_val("m_hit_valid",   hit_valid,   (m_q.size() > 0));
    check_val("m_hit_nonce",   hit_nonce,   (m_q.size() > 0) ? m_q[0].nonce : 32'h0);
    check_val("m_hit_id",      hit_id,      (m_q.size() > 0) ? m_q[0].id : 8'h0);
    check_val("m_nonce_cur",   nonce_cur,   m_nonce_cur);
    check_val("m_midstate",    miner_midstate, m_mid);
    check_val("m_data",        miner_data,  m_data);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_output();
  endtask

  task automatic wait_load(input string name, input int already);
    int n;
    n = already;
    while (n < 400) begin
      tick();
      if (miner_reset !== 1'b1) break;
      n++;
    end
    check_val(name, n, RESET_CYCLES);
  endtask

  task automatic apply_stimulus();
    work_valid = ($urandom_range(0, 399) == 0);
    if (work_valid) begin
      work_id       = 8'($urandom);
      work_midstate = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      work_data     = {$urandom, $urandom, $urandom};
    end
    if ($urandom_range(0, 99) < 15) miner_golden = $urandom | 32'h1;
    if ($urandom_range(0, 99) < 2) miner_nonce2 = $urandom;
    else                           miner_nonce2 = miner_nonce2 + 32'($urandom_range(0, 5));
    hit_ready = ($urandom_range(0, 2) == 0);
  endtask

  typedef struct {
    logic [31:0] golden;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_nonce;
    logic [7:0]  exp_id;
    logic        exp_ovf;
  } vec_t;

  vec_t         vecs[NVEC];
  logic [31:0]  drain_exp[4];
  logic [255:0] job_mid;
  logic [95:0]  job_data;

  initial begin
    vecs[0]  = '{32'h0,        1'b0, 1'b0, 32'h0,        8'h00, 1'b0};
    vecs[1]  = '{32'h0,        1'b0, 1'b0, 32'h0,        8'h00, 1'b0};
    vecs[2]  = '{32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        8'h00, 1'b0};
    vecs[3]  = '{32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 8'h11, 1'b0};
    vecs[4]  = '{32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 8'h11, 1'b0};
    vecs[5]  = '{32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 8'h11, 1'b0};
    vecs[6]  = '{32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        8'h00, 1'b0};
    vecs[7]  = '{32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        8'h00, 1'b0};
    vecs[8]  = '{32'hA0000001, 1'b0, 1'b0, 32'h0,        8'h00, 1'b0};
    vecs[9]  = '{32'hA0000002, 1'b0, 1'b1, 32'hA0000001, 8'h11, 1'b0};
    vecs[10] = '{32'hA0000003, 1'b0, 1'b1, 32'hA0000001, 8'h11, 1'b0};
    vecs[11] = '{32'hA0000004, 1'b0, 1'b1, 32'hA0000001, 8'h11, 1'b0};
    vecs[12] = '{32'hA0000005, 1'b0, 1'b1, 32'hA0000001, 8'h11, 1'b0};
    vecs[13] = '{32'hA0000005, 1'b0, 1'b1, 32'hA0000001, 8'h11, 1'b1};
    vecs[14] = '{32'hA0000006, 1'b0, 1'b1, 32'hA0000001, 8'h11, 1'b1};
    vecs[15] = '{32'hA0000006, 1'b1, 1'b1, 32'hA0000002, 8'h11, 1'b1};
    vecs[16] = '{32'hA0000006, 1'b0, 1'b1, 32'hA0000002, 8'h11, 1'b1};
    drain_exp[0] = 32'hA0000002;
    drain_exp[1] = 32'hA0000003;
    drain_exp[2] = 32'hA0000004;
    drain_exp[3] = 32'hA0000006;

    model_reset();
    reset_n       = 1'b1;
    work_valid    = 1'b0;
    work_midstate = '0;
    work_data     = '0;
    work_id       = '0;
    miner_golden  = '0;
    miner_nonce2  = '0;
    hit_ready     = 1'b0;

    // Reset and idle.
    #2 reset_n = 1'b0;
    repeat (3) tick();
    check_val("rst_miner_reset", miner_reset, 1);
    check_val("rst_work_ready",  work_ready, 1);
    check_val("rst_hit_valid",   hit_valid, 0);
    check_val("rst_busy",        busy, 0);
    check_val("rst_exhausted",   exhausted, 0);
    check_val("rst_overflow",    hit_overflow, 0);
    check_val("rst_midstate",    miner_midstate, 0);
    check_val("rst_nonce_cur",   nonce_cur, 0);
    reset_n = 1'b1;
    repeat (6) tick();
    check_val("idle_miner_reset", miner_reset, 1);
    check_val("idle_busy",        busy, 0);

    // Job 0x11: core reset must last exactly RESET_CYCLES.
    miner_nonce2  = 32'h100;
    job_mid       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    job_data      = {$urandom, $urandom, $urandom};
    work_midstate = job_mid;
    work_data     = job_data;
    work_id       = 8'h11;
    work_valid    = 1'b1;
    tick();
    work_valid = 1'b0;
    check_val("load_miner_reset", miner_reset, 1);
    check_val("load_busy",        busy, 1);
    check_val("load_work_ready",  work_ready, 0);
    check_val("load_midstate",    miner_midstate, job_mid);
    check_val("load_data",        miner_data, job_data);
    wait_load("load_len_11", 1);
    check_val("run_miner_reset", miner_reset, 0);
    check_val("run_work_ready",  work_ready, 1);

    // Hit queue and overflow vectors.
    for (int i = 0; i < NVEC; i++) begin
      miner_golden = vecs[i].golden;
      hit_ready    = vecs[i].ready;
      tick();
      check_val($sformatf("vec%0d_hit_valid", i), hit_valid, vecs[i].exp_valid);
      check_val($sformatf("vec%0d_hit_nonce", i), hit_nonce, vecs[i].exp_nonce);
      check_val($sformatf("vec%0d_hit_id", i),    hit_id,    vecs[i].exp_id);
      check_val($sformatf("vec%0d_overflow", i),  hit_overflow, vecs[i].exp_ovf);
    end
    hit_ready = 1'b0;

    // Preempt job 0x11 with 0x22 while a hit is staged.
    miner_golden = 32'hA0000007;
    tick();
    work_id    = 8'h22;
    work_valid = 1'b1;
    tick();
    work_valid = 1'b0;
    check_val("pre_miner_reset", miner_reset, 1);
    check_val("pre_overflow",    hit_overflow, 0);
    check_val("pre_exhausted",   exhausted, 0);
    check_val("pre_hit_valid",   hit_valid, 1);
    miner_golden = 32'hA0000008;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("drain%0d_nonce", k), hit_nonce, drain_exp[k]);
      check_val($sformatf("drain%0d_id", k),    hit_id, 8'h11);
      hit_ready = 1'b1;
      tick();
      hit_ready = 1'b0;
    end
    repeat (3) tick();
    check_val("load_golden_ignored", hit_valid, 0);
    miner_golden = '0;
    wait_load("load_len_22", 8);

    // Nonce wrap moves the job to EXH while the core keeps hashing.
    miner_nonce2 = 32'hFFFFFFFE;
    tick();
    check_val("prewrap_exhausted", exhausted, 0);
    miner_nonce2 = 32'h00000001;
    tick();
    check_val("wrap_exhausted",   exhausted, 1);
    check_val("wrap_work_ready",  work_ready, 1);
    check_val("wrap_miner_reset", miner_reset, 0);
    check_val("wrap_busy",        busy, 0);
    check_val("wrap_nonce_cur",   nonce_cur, 32'h1);
    miner_golden = 32'hB0000009;
    repeat (2) tick();
    check_val("exh_hit_nonce", hit_nonce, 32'hB0000009);
    check_val("exh_hit_id",    hit_id, 8'h22);
    work_id    = 8'h33;
    work_valid = 1'b1;
    tick();
    work_valid = 1'b0;
    check_val("exh_preempt_exhausted", exhausted, 0);
    check_val("exh_preempt_reset",     miner_reset, 1);
    wait_load("load_len_33", 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus();
      tick();
    end

    // Asynchronous reset in the middle of a job.
    work_valid   = 1'b0;
    hit_ready    = 1'b0;
    miner_golden = 32'h12345678;
    repeat (300) tick();
    #2 reset_n = 1'b0;
    #1;
    check_val("async_miner_reset", miner_reset, 1);
    check_val("async_busy",        busy, 0);
    check_val("async_hit_valid",   hit_valid, 0);
    check_val("async_midstate",    miner_midstate, 0);
    check_val("async_nonce_cur",   nonce_cur, 0);
    check_output();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
